spi_dac_receiver: RTL and testbench

SPI responder for the DAC frame path. It samples SPI_SCK, SPI_MOSI and DAC_CS in the system clock domain and deserialises each frame while DAC_CS is low. On frame end it decodes the frame into command, address and 12-bit data with a one-cycle valid strobe. It echoes the previous good frame on SPI_MISO. It serves as the in-fabric DAC model for loopback and self-check of the SPI transmit path.

---
 rtl/spi_dac_receiver.sv | 157 +++++++++++++++
 tb/tb_spi_dac_receiver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_receiver.sv
// SPI responder for the DAC frame path: deserialises frames in the clk domain,
// decodes cmd/addr/data and echoes the previous good frame on SPI_MISO.
module spi_dac_receiver #(
  parameter int FRAME_BITS  = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_Async,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        DAC_CS,
  output logic        SPI_MISO,
  output logic [3:0]  rx_cmd,
  output logic [3:0]  rx_addr,
  output logic [11:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [SYNC_STAGES:0]   live_q;
  logic                   sck_s, cs_s, mosi_s, live;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0]   echo_q, echo_d;
  logic                    miso_q, miso_d;
  logic [3:0]              cmd_q, cmd_d, addr_q, addr_d;
  logic [11:0]             data_q, data_d;
  logic                    valid_q, valid_d, err_q, err_d;

  always_ff @(posedge clk or posedge reset_Async) begin
    if (reset_Async) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      live_q      <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], DAC_CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      live_q      <= {live_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edges are masked until the synchronisers have flushed their reset values,
  // so a CS held low through reset release is not mistaken for a frame start.
  assign live     = live_q[SYNC_STAGES];
  assign sck_rise = live & sck_s & ~sck_prev_q;
  assign sck_fall = live & ~sck_s & sck_prev_q;
  assign cs_rise  = live & cs_s & ~cs_prev_q;
  assign cs_fall  = live & ~cs_s & cs_prev_q;

  always_ff @(posedge clk or posedge reset_Async) begin
    if (reset_Async) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
      echo_q  <= '0;
      miso_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
      echo_q  <= echo_d;
      miso_q  <= miso_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_sr_d = rx_sr_q;
    tx_sr_d = tx_sr_q;
    echo_d  = echo_q;
    miso_d  = miso_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          cnt_d   = '0;
          tx_sr_d = echo_q;
          miso_d  = echo_q[FRAME_BITS-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = DONE;
        end else begin
          if (sck_rise) begin
            rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], mosi_s};
            cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
          end
          if (sck_fall) begin
            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
            miso_d  = tx_sr_q[FRAME_BITS-2];
          end
        end
      end
      DONE: begin
        if (cnt_q == FRAME_CNT) begin
          cmd_d   = rx_sr_q[FRAME_BITS-1 -: 4];
          addr_d  = rx_sr_q[FRAME_BITS-5 -: 4];
          data_d  = rx_sr_q[FRAME_BITS-9 -: 12];
          echo_d  = rx_sr_q;
          valid_d = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SPI_MISO = miso_q;
  assign rx_cmd   = cmd_q;
  assign rx_addr  = addr_q;
  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed bench for spi_dac_receiver: frames are driven at SCK=clk/8 and a
// scoreboard queue checks each rx_valid/rx_err pulse, its latency and MISO echo.
module tb_spi_dac_receiver;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_Async;
  logic        SPI_SCK, SPI_MOSI, DAC_CS;
  logic        SPI_MISO;
  logic [3:0]  rx_cmd, rx_addr;
  logic [11:0] rx_data;
  logic        rx_valid, rx_err;

  spi_dac_receiver #(.FRAME_BITS(28), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .reset_Async (reset_Async),
    .SPI_SCK     (SPI_SCK),
    .SPI_MOSI    (SPI_MOSI),
    .DAC_CS      (DAC_CS),
    .SPI_MISO    (SPI_MISO),
    .rx_cmd      (rx_cmd),
    .rx_addr     (rx_addr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    int          rise;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [27:0] echo_m = '0;
  logic [27:0] good_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1 || rx_err === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rx_valid, rx_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_err", {30'd0, rx_valid, rx_err}, {30'd0, ~e.err, e.err});
        chk("latency", cyc - e.rise, SYNC + 2);
        chk("cmd", {28'd0, rx_cmd}, {28'd0, e.cmd});
        chk("addr", {28'd0, rx_addr}, {28'd0, e.addr});
        chk("data", {20'd0, rx_data}, {20'd0, e.data});
      end
    end
  end

  task automatic sck_pulse();
    repeat (4) @(negedge clk);
    SPI_SCK = 1'b1;
    repeat (4) @(negedge clk);
    SPI_SCK = 1'b0;
  endtask

  // Drives one frame of n bits (MSB first), checks MISO against the echo model
  // and pushes the expected decode onto the scoreboard at CS rise.
  task automatic send_frame(input logic [31:0] w, input int n, input int gap);
    logic [31:0] cap, expm;
    exp_t        e;
    cap  = '0;
    expm = '0;
    @(negedge clk);
    DAC_CS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      int j;
      j = n - 1 - i;
      SPI_MOSI = w[i];
      repeat (4) @(negedge clk);
      cap  = {cap[30:0], SPI_MISO};
      expm = {expm[30:0], (j < 28) ? echo_m[27 - j] : 1'b0};
      SPI_SCK = 1'b1;
      repeat (4) @(negedge clk);
      SPI_SCK = 1'b0;
    end
    repeat (4) @(negedge clk);
    DAC_CS = 1'b1;
    e.err  = (n != 28);
    if (n == 28) good_m = w[27:0];
    e.cmd  = good_m[27:24];
    e.addr = good_m[23:20];
    e.data = good_m[19:8];
    e.rise = cyc;
    sb.push_back(e);
    chk($sformatf("miso_echo_%0d", n), cap, expm);
    if (n == 28) echo_m = w[27:0];
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    reset_Async = 1'b1;
    SPI_SCK     = 1'b0;
    SPI_MOSI    = 1'b0;
    DAC_CS      = 1'b1;
    repeat (3) @(negedge clk);
    reset_Async = 1'b0;
    @(negedge clk);
    chk("rst_cmd", {28'd0, rx_cmd}, 32'd0);
    chk("rst_addr", {28'd0, rx_addr}, 32'd0);
    chk("rst_data", {20'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_err", {31'd0, rx_err}, 32'd0);
    chk("rst_miso", {31'd0, SPI_MISO}, 32'd0);
    repeat (4) @(negedge clk);

    send_frame(32'h30ABC5A, 28, 10);
    send_frame(32'h0012345, 20, 10);
    send_frame(32'h2AAAAAAA, 30, 10);
    send_frame(32'hF5FFF00, 28, 10);
    send_frame(32'h30ABC5A, 28, 10);
    send_frame(32'h1234567, 28, 10);
    send_frame(32'hABCDEF1, 28, 10);
    drain();

    // Reset in the middle of a frame, then finish the frame with no response.
    @(negedge clk);
    DAC_CS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      SPI_MOSI = i[0];
      sck_pulse();
    end
    @(negedge clk);
    reset_Async = 1'b1;
    #1;
    chk("mid_rst_cmd", {28'd0, rx_cmd}, 32'd0);
    chk("mid_rst_addr", {28'd0, rx_addr}, 32'd0);
    chk("mid_rst_data", {20'd0, rx_data}, 32'd0);
    chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, rx_err}, 32'd0);
    chk("mid_rst_miso", {31'd0, SPI_MISO}, 32'd0);
    repeat (3) @(negedge clk);
    reset_Async = 1'b0;
    echo_m = '0;
    good_m = '0;
    for (int i = 0; i < 18; i++) begin
      SPI_MOSI = ~i[0];
      sck_pulse();
    end
    repeat (4) @(negedge clk);
    DAC_CS = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(32'h7654321, 28, 10);
    send_frame(32'h1111110, 28, 1);
    send_frame(32'h2222220, 28, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
